// File: rtl/pixel_frame_source_if.sv
// Pixel stream bus between pixel_frame_source and its sink: data, valid/ready
// handshake and the sof/eol/eof frame markers.
interface pixel_frame_source_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pixel;
  logic             pixel_valid;
  logic             pixel_ready;
  logic             sof;
  logic             eol;
  logic             eof;

  // Source side drives data, valid and markers; sink side drives ready.
  modport master (
    output pixel, pixel_valid, sof, eol, eof,
    input  pixel_ready
  );

  modport slave (
    input  pixel, pixel_valid, sof, eol, eof,
    output pixel_ready
  );
endinterface

// File: rtl/pixel_frame_source.sv
// pixel_frame_source: synthetic raster image generator with valid/ready
// backpressure, sof/eol/eof markers and programmable horizontal/vertical
// blanking. Patterns: 0 ramp (x+y), 1 checkerboard, 2 column gradient (x),
// 3 constant.
// Optional build macro PIXSRC_STALL_INJECT_EN: a 16-bit LFSR withholds
// not-yet-presented pixels to exercise sink handshaking. Without it the
// source never inserts bubbles inside a row.
module pixel_frame_source #(
  parameter int PIX_W   = 8,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int HBLANK  = 4,
  parameter int VBLANK  = 16,
  parameter int SQ_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 continuous_i,
  input  logic [1:0]           mode_i,
  input  logic [PIX_W-1:0]     const_val_i,
  pixel_frame_source_if.master pix_if,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  // Keep the blanking counter at least one bit wide when both blanks are 0.
  localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic [1:0]       mode_q, mode_d;
  logic [PIX_W-1:0] const_q, const_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic             active;
  logic             valid;
  logic             xfer;
  logic             frame_end;
  logic [PIX_W-1:0] pix_val;

  assign active = (state_q == S_ACTIVE);

`ifdef PIXSRC_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;
  // shown_q: current pixel has already been offered, so it must stay valid.
  logic        shown_q, shown_d;

  // Fibonacci LFSR, taps 16,14,13,11, advancing every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign valid   = active && (shown_q || !lfsr_q[0]);
  assign shown_d = valid && !pix_if.pixel_ready && !abort_i;

  // Stall-injection state: LFSR reseeded on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q  <= 16'hACE1;
      shown_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      shown_q <= shown_d;
    end
  end
`else
  assign valid = active;
`endif

  assign xfer = valid && pix_if.pixel_ready;

  // Pattern generator from the current raster coordinates and latched mode.
  always_comb begin
    pix_val = '0;
    case (mode_q)
      2'd0:    pix_val = PIX_W'(32'(x_q) + 32'(y_q));
      2'd1:    pix_val = ((((32'(x_q) ^ 32'(y_q)) >> SQ_LOG2) & 32'd1) != 32'd0) ? '1 : '0;
      2'd2:    pix_val = PIX_W'(32'(x_q));
      default: pix_val = const_q;
    endcase
  end

  // Next-state logic: raster walk, blanking countdown and frame completion.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    blank_d      = blank_q;
    mode_d       = mode_q;
    const_d      = const_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    frame_end    = 1'b0;

    if (abort_i) begin
      // Abort wins over everything and discards the partial frame.
      state_d = S_IDLE;
      x_d     = '0;
      y_d     = '0;
      blank_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            mode_d  = mode_i;
            const_d = const_val_i;
          end
        end
        S_ACTIVE: begin
          if (xfer) begin
            if (x_q != X_LAST) begin
              x_d = x_q + 1'b1;
            end else if (y_q != Y_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
              if (HBLANK > 0) begin
                state_d = S_HBLANK;
                blank_d = BW'(HBLANK - 1);
              end
            end else begin
              x_d = '0;
              y_d = '0;
              if (VBLANK > 0) begin
                state_d = S_VBLANK;
                blank_d = BW'(VBLANK - 1);
              end else begin
                frame_end = 1'b1;
              end
            end
          end
        end
        S_HBLANK: begin
          if (blank_q == '0) begin
            state_d = S_ACTIVE;
          end else begin
            blank_d = blank_q - 1'b1;
          end
        end
        S_VBLANK: begin
          if (blank_q == '0) begin
            frame_end = 1'b1;
          end else begin
            blank_d = blank_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Frame completion: count it, then restart or go idle.
      if (frame_end) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 16'd1;
        if (continuous_i) begin
          state_d = S_ACTIVE;
          mode_d  = mode_i;
          const_d = const_val_i;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      blank_q      <= '0;
      mode_q       <= 2'd0;
      const_q      <= '0;
      frame_cnt_q  <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      blank_q      <= blank_d;
      mode_q       <= mode_d;
      const_q      <= const_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Data and markers are forced low outside ACTIVE so idle/blank cycles are clean.
  assign pix_if.pixel       = active ? pix_val : '0;
  assign pix_if.pixel_valid = valid;
  assign pix_if.sof         = active && (x_q == '0) && (y_q == '0);
  assign pix_if.eol         = active && (x_q == X_LAST);
  assign pix_if.eof         = active && (x_q == X_LAST) && (y_q == Y_LAST);

  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_frame_source.sv
// Bench for pixel_frame_source: two instances (blanking on / blanking zero),
// scoreboard of expected pixels filled before each frame and drained on
// every accepted transfer.
module tb_pixel_frame_source;

  localparam int PW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [PW-1:0] const_val = '0;
  logic        tb_ready = 1'b1;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  pixel_frame_source_if #(.PIX_W(PW)) if_a ();
  pixel_frame_source_if #(.PIX_W(PW)) if_b ();

  assign if_a.pixel_ready = tb_ready;
  assign if_b.pixel_ready = tb_ready;

  pixel_frame_source #(.PIX_W(PW), .IMG_W(4), .IMG_H(2), .HBLANK(2), .VBLANK(3), .SQ_LOG2(1)) dut_a (
    .clk(clk), .reset(reset), .start_i(start_a), .abort_i(abort), .continuous_i(continuous),
    .mode_i(mode), .const_val_i(const_val), .pix_if(if_a),
    .busy_o(busy_a), .frame_done_o(done_a), .frame_cnt_o(cnt_a)
  );

  pixel_frame_source #(.PIX_W(PW), .IMG_W(4), .IMG_H(4), .HBLANK(0), .VBLANK(0), .SQ_LOG2(1)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b), .abort_i(abort), .continuous_i(continuous),
    .mode_i(mode), .const_val_i(const_val), .pix_if(if_b),
    .busy_o(busy_b), .frame_done_o(done_b), .frame_cnt_o(cnt_b)
  );

  // Observation mux: sel_b picks which instance the scoreboard watches.
  logic          sel_b = 1'b0;
  logic          m_valid, m_sof, m_eol, m_eof, m_done, m_busy;
  logic [PW-1:0] m_pix;
  logic [15:0]   m_cnt;
  assign m_valid = sel_b ? if_b.pixel_valid : if_a.pixel_valid;
  assign m_sof   = sel_b ? if_b.sof : if_a.sof;
  assign m_eol   = sel_b ? if_b.eol : if_a.eol;
  assign m_eof   = sel_b ? if_b.eof : if_a.eof;
  assign m_pix   = sel_b ? if_b.pixel : if_a.pixel;
  assign m_done  = sel_b ? done_b : done_a;
  assign m_busy  = sel_b ? busy_b : busy_a;
  assign m_cnt   = sel_b ? cnt_b : cnt_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [PW-1:0] pix;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  exp_t        exp_q[$];
  int          xfer_cyc[$];
  int          done_cyc[$];
  logic [15:0] done_cnt[$];
  logic        done_busy[$];
  int          errors = 0;
  int          checks = 0;
  int          start_cyc = 0;
  logic [15:0] exp_cnt_a = 16'd0;

  // Reference model of one frame pushed onto the scoreboard.
  function automatic void push_frame(input int w, input int h, input int md,
                                     input logic [PW-1:0] cv, input int sq);
    exp_t e;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        case (md)
          0:       e.pix = PW'(x + y);
          1:       e.pix = ((((x >> sq) ^ (y >> sq)) & 1) != 0) ? 8'hFF : 8'h00;
          2:       e.pix = PW'(x);
          default: e.pix = cv;
        endcase
        e.sof = (x == 0) && (y == 0);
        e.eol = (x == w - 1);
        e.eof = (x == w - 1) && (y == h - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic pulse_start(input bit use_b);
    @(negedge clk);
    start_cyc = cyc;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Runs cycles until the scoreboard is empty and want_done frame_done pulses
  // are seen; optionally holds ready low 3 cycles when transfer stall_idx is offered.
  task automatic drain(input int budget, input int want_done, input int stall_idx);
    int   n;
    int   left;
    int   waited;
    bit   stalled;
    exp_t e;
    n = 0; left = 0; waited = 0; stalled = 0;
    xfer_cyc.delete(); done_cyc.delete(); done_cnt.delete(); done_busy.delete();
    while ((exp_q.size() > 0 || done_cyc.size() < want_done) && waited < budget) begin
      @(negedge clk);
      waited++;
      if (m_done === 1'b1) begin
        done_cyc.push_back(cyc);
        done_cnt.push_back(m_cnt);
        done_busy.push_back(m_busy);
        if (done_cyc.size() == want_done - 1) continuous = 1'b0;
      end
      if (left > 0) begin
        checks++;
        if (m_valid !== 1'b1 || m_pix !== 8'd2) begin
          errors++;
          $display("FAIL stall_hold: valid=%b pixel=%h, required valid=1 pixel=02", m_valid, m_pix);
        end
        left--;
        if (left == 0) tb_ready = 1'b1;
      end else if (stall_idx >= 0 && !stalled && m_valid === 1'b1 && n == stall_idx) begin
        stalled  = 1'b1;
        left     = 3;
        tb_ready = 1'b0;
      end
      if (m_valid === 1'b1 && tb_ready) begin
        xfer_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel: pixel=%h sof=%b with empty scoreboard", m_pix, m_sof);
        end else begin
          e = exp_q.pop_front();
          if ({m_pix, m_sof, m_eol, m_eof} !== {e.pix, e.sof, e.eol, e.eof}) begin
            errors++;
            $display("FAIL pixel_%0d: got pix=%h sof=%b eol=%b eof=%b, required pix=%h sof=%b eol=%b eof=%b",
                     n, m_pix, m_sof, m_eol, m_eof, e.pix, e.sof, e.eol, e.eof);
          end else begin
            $display("xfer %0d cyc=%0d pix=%h sof=%b eol=%b eof=%b", n, cyc, m_pix, m_sof, m_eol, m_eof);
          end
        end
        n++;
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_cyc.size() < want_done) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d dones=%0d, required pending=0 dones=%0d",
               exp_q.size(), done_cyc.size(), want_done);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_a.pixel_valid, busy_a, done_a, if_a.sof, if_a.eol, if_a.eof} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/busy/done/sof/eol/eof=%b, required 000000",
               {if_a.pixel_valid, busy_a, done_a, if_a.sof, if_a.eol, if_a.eof});
    end
    checks++;
    if (if_a.pixel !== 8'h00 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: pixel=%h frame_cnt=%h, required 00 / 0000", if_a.pixel, cnt_a);
    end
    checks++;
    if (busy_b !== 1'b0 || if_b.pixel_valid !== 1'b0 || cnt_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_b: busy=%b valid=%b cnt=%h, required 0 0 0000", busy_b, if_b.pixel_valid, cnt_b);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp_frame();
    sel_b = 1'b0; mode = 2'd0; tb_ready = 1'b1;
    push_frame(4, 2, 0, 8'h00, 1);
    pulse_start(1'b0);
    mode = 2'd3; const_val = 8'h77;   // must not affect the running frame
    drain(100, 1, -1);
    exp_cnt_a = exp_cnt_a + 16'd1;
    checks++;
    if (xfer_cyc.size() == 8 && done_cyc.size() == 1) begin
      if (xfer_cyc[0] != start_cyc + 1 || xfer_cyc[4] - xfer_cyc[3] != 3 || xfer_cyc[7] - xfer_cyc[0] != 9) begin
        errors++;
        $display("FAIL ramp_timing: first=%0d hgap=%0d span=%0d, required %0d 3 9",
                 xfer_cyc[0], xfer_cyc[4] - xfer_cyc[3], xfer_cyc[7] - xfer_cyc[0], start_cyc + 1);
      end
      checks++;
      if (done_cyc[0] - xfer_cyc[7] != 4 || done_cnt[0] !== exp_cnt_a || done_busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL ramp_done: delay=%0d cnt=%h busy=%b, required 4 %h 0",
                 done_cyc[0] - xfer_cyc[7], done_cnt[0], done_busy[0], exp_cnt_a);
      end
    end else begin
      errors++;
      $display("FAIL ramp_count: xfers=%0d dones=%0d, required 8 1", xfer_cyc.size(), done_cyc.size());
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL ramp_pulse: frame_done=%b busy=%b one cycle later, required 0 0", m_done, m_busy);
    end
  endtask

  task automatic test_checkerboard();
    sel_b = 1'b1; mode = 2'd1;
    push_frame(4, 4, 1, 8'h00, 1);
    pulse_start(1'b1);
    drain(100, 1, -1);
    checks++;
    if (xfer_cyc.size() == 16 && done_cyc.size() == 1) begin
      if (xfer_cyc[15] - xfer_cyc[0] != 15 || done_cyc[0] - xfer_cyc[15] != 1 || done_cnt[0] !== 16'd1) begin
        errors++;
        $display("FAIL checker_zero_blank: span=%0d done_delay=%0d cnt=%h, required 15 1 0001",
                 xfer_cyc[15] - xfer_cyc[0], done_cyc[0] - xfer_cyc[15], done_cnt[0]);
      end
    end else begin
      errors++;
      $display("FAIL checker_count: xfers=%0d dones=%0d, required 16 1", xfer_cyc.size(), done_cyc.size());
    end
    sel_b = 1'b0;
  endtask

  task automatic test_backpressure();
    mode = 2'd0;
    push_frame(4, 2, 0, 8'h00, 1);
    pulse_start(1'b0);
    drain(100, 1, 2);
    exp_cnt_a = exp_cnt_a + 16'd1;
    checks++;
    if (xfer_cyc.size() == 8 && done_cyc.size() == 1) begin
      if (xfer_cyc[2] - xfer_cyc[1] != 4 || xfer_cyc[3] - xfer_cyc[2] != 1 ||
          xfer_cyc[7] - xfer_cyc[0] != 12 || done_cnt[0] !== exp_cnt_a) begin
        errors++;
        $display("FAIL bp_timing: gap12=%0d gap23=%0d span=%0d cnt=%h, required 4 1 12 %h",
                 xfer_cyc[2] - xfer_cyc[1], xfer_cyc[3] - xfer_cyc[2], xfer_cyc[7] - xfer_cyc[0],
                 done_cnt[0], exp_cnt_a);
      end
    end else begin
      errors++;
      $display("FAIL bp_count: xfers=%0d dones=%0d, required 8 1", xfer_cyc.size(), done_cyc.size());
    end
    tb_ready = 1'b1;
  endtask

  task automatic test_continuous();
    mode = 2'd3; const_val = 8'h5A; continuous = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(4, 2, 3, 8'h5A, 1);
    pulse_start(1'b0);
    drain(300, 3, -1);
    checks++;
    if (xfer_cyc.size() == 24 && done_cyc.size() == 3) begin
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (done_cnt[f] !== exp_cnt_a + 16'(f + 1)) begin
          errors++;
          $display("FAIL cont_cnt_%0d: frame_cnt=%h, required %h", f, done_cnt[f], exp_cnt_a + 16'(f + 1));
        end
      end
      for (int f = 0; f < 2; f++) begin
        checks++;
        if (xfer_cyc[8*f+8] - xfer_cyc[8*f+7] != 4 || done_cyc[f] != xfer_cyc[8*f+8]) begin
          errors++;
          $display("FAIL cont_gap_%0d: eof_to_sof=%0d done_cyc=%0d sof_cyc=%0d, required 4 and equal",
                   f, xfer_cyc[8*f+8] - xfer_cyc[8*f+7], done_cyc[f], xfer_cyc[8*f+8]);
        end
      end
      checks++;
      if (done_busy[2] !== 1'b0) begin
        errors++;
        $display("FAIL cont_stop: busy=%b after last frame, required 0", done_busy[2]);
      end
    end else begin
      errors++;
      $display("FAIL cont_count: xfers=%0d dones=%0d, required 24 3", xfer_cyc.size(), done_cyc.size());
    end
    exp_cnt_a = exp_cnt_a + 16'd3;
    continuous = 1'b0;
  endtask

  task automatic test_abort();
    int dones;
    mode = 2'd0;
    push_frame(4, 2, 0, 8'h00, 1);
    repeat (3) void'(exp_q.pop_back());
    pulse_start(1'b0);
    drain(50, 0, -1);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_pix !== 8'd2) begin
      errors++;
      $display("FAIL abort_pre: valid=%b pixel=%h at (1,1), required 1 02", m_valid, m_pix);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_cnt !== exp_cnt_a || m_sof !== 1'b0) begin
      errors++;
      $display("FAIL abort_post: valid=%b busy=%b cnt=%h sof=%b, required 0 0 %h 0",
               m_valid, m_busy, m_cnt, m_sof, exp_cnt_a);
    end
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || m_cnt !== exp_cnt_a) begin
      errors++;
      $display("FAIL abort_nodone: pulses=%0d cnt=%h, required 0 %h", dones, m_cnt, exp_cnt_a);
    end
    push_frame(4, 2, 0, 8'h00, 1);
    pulse_start(1'b0);
    drain(100, 1, -1);
    exp_cnt_a = exp_cnt_a + 16'd1;
    checks++;
    if (done_cyc.size() != 1 || done_cnt[0] !== exp_cnt_a) begin
      errors++;
      $display("FAIL abort_restart: dones=%0d cnt=%h, required 1 %h",
               done_cyc.size(), (done_cnt.size() > 0) ? done_cnt[0] : 16'hxxxx, exp_cnt_a);
    end
  endtask

  task automatic test_reset_hblank();
    mode = 2'd0;
    push_frame(4, 2, 0, 8'h00, 1);
    repeat (4) void'(exp_q.pop_back());
    pulse_start(1'b0);
    drain(50, 0, -1);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b1) begin
      errors++;
      $display("FAIL hblank_state: valid=%b busy=%b, required 0 1", m_valid, m_busy);
    end
    reset = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_valid, m_busy, m_done, m_sof, m_eol, m_eof} !== 6'b0 || m_pix !== 8'h00 || m_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b pixel=%h cnt=%h, required 000000 00 0000",
               {m_valid, m_busy, m_done, m_sof, m_eol, m_eof}, m_pix, m_cnt);
    end
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b valid=%b, required 0 0", m_busy, m_valid);
    end
    start_a = 1'b0;
    reset = 1'b1;
    exp_cnt_a = 16'd0;
    repeat (2) @(negedge clk);
    push_frame(4, 2, 0, 8'h00, 1);
    pulse_start(1'b0);
    drain(100, 1, -1);
    checks++;
    if (done_cyc.size() != 1 || done_cnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL reset_recover: dones=%0d cnt=%h, required 1 0001",
               done_cyc.size(), (done_cnt.size() > 0) ? done_cnt[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_checkerboard();
    test_backpressure();
    test_continuous();
    test_abort();
    test_reset_hblank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_frame_source.md
Name: pixel_frame_source

Overview:
Synthesizable, parametrised pixel stream source that replaces file-fed stimulus for the harris detector front end. Generates framed raster images (ramp, checkerboard, column gradient, constant) with valid/ready backpressure, row/frame markers and programmable horizontal/vertical blanking. Sits ahead of harrisDetector on-chip for BIST and in benches as a reusable driver.

Parameters:
PIX_W, 8, pixel width in bits
IMG_W, 64, pixels per row (>=2)
IMG_H, 64, rows per frame (>=2)
HBLANK, 4, idle cycles after each row (0 allowed)
VBLANK, 16, idle cycles after each frame (0 allowed)
SQ_LOG2, 3, log2 of checkerboard square size in pixels

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a frame; honoured only in IDLE
abort  in  1  synchronous stop; returns to IDLE next cycle
continuous  in  1  when 1, next frame starts automatically after VBLANK
mode  in  2  0 ramp, 1 checkerboard, 2 column gradient, 3 constant
const_val  in  PIX_W  pixel value for mode 3
pixel  out  PIX_W  pixel data
pixel_valid  out  1  pixel is presented
pixel_ready  in  1  sink accepts pixel
sof  out  1  qualifies pixel (0,0)
eol  out  1  qualifies last pixel of a row
eof  out  1  qualifies last pixel of frame
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after VBLANK completes
frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (reset==0 at edge): state IDLE; pixel, pixel_valid, sof, eol, eof, busy, frame_done, frame_cnt all 0; x=y=0.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: start==1 at edge n -> ACTIVE; mode, const_val latched at edge n; pixel (0,0) with pixel_valid=1, sof=1 visible after edge n (latency 1 cycle).
- ACTIVE: transfer when pixel_valid && pixel_ready at an edge. Without transfer, pixel/sof/eol/eof held stable, valid never retracted (except abort/reset).
- After transfer of x<IMG_W-1: x++, next pixel presented next cycle (no bubble).
- After transfer of x==IMG_W-1, y<IMG_H-1: x=0, y++; HBLANK>0 -> HBLANK state for exactly HBLANK cycles, valid low; HBLANK==0 -> next row presented next cycle.
- After transfer of eof pixel: VBLANK for VBLANK cycles (VBLANK==0 -> zero cycles). On leaving VBLANK: frame_done pulses 1 cycle, frame_cnt++; then continuous==1 -> ACTIVE with new (0,0), mode/const_val re-latched; else IDLE.
- frame_done, frame_cnt update coincide with first cycle of next sof pixel in continuous mode.
- Pixel values (x,y counters, result truncated to PIX_W): ramp = x+y; checkerboard = ((x>>SQ_LOG2)^(y>>SQ_LOG2))[0] ? all-ones : 0; gradient = x; constant = const_val.
- abort==1 at any edge (priority over start/transfer): next state IDLE, valid/markers low, x=y=0, no frame_done, frame_cnt unchanged.
- start while busy ignored. mode/const_val changes mid-frame ignored.
- Counters sized $clog2(IMG_W), $clog2(IMG_H), $clog2(max(HBLANK,VBLANK)+1).

Optional Feature:
PIXSRC_STALL_INJECT_EN: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, reloaded on reset, steps every cycle). In ACTIVE, a not-yet-presented pixel is withheld (valid stays 0) in any cycle LFSR[0]==1; once valid rises it holds until transfer. Markers/values unchanged. Without macro: no LFSR, no bubbles, behaviour exactly as above.

Test Plan:
IMG_W=4, IMG_H=2, HBLANK=2, VBLANK=3, mode 0, ready=1, start pulse -> pixels 0,1,2,3, 2 idle cycles, 1,2,3,4; sof on first, eol on 3 and 4th-of-row2, eof on last; 3 cycles later frame_done pulse, frame_cnt=1, IDLE.
Mode 1, SQ_LOG2=1, IMG_W=4, IMG_H=4, PIX_W=8 -> rows 00,00,FF,FF / 00,00,FF,FF / FF,FF,00,00 / FF,FF,00,00.
Ready low 3 cycles while pixel (2,0) presented -> valid stays 1, pixel=2 stable, next value 3 only after ready returns; total frame length +3 cycles.
continuous=1, mode 3, const_val=8'h5A, 3 frames -> all pixels 5A, exactly 3 non-valid VBLANK cycles between eof and next sof, frame_cnt 1,2,3.
abort at pixel (1,1) -> next cycle valid=0, busy=0, frame_cnt unchanged; start afterwards restarts at (0,0) with sof.
reset low mid-HBLANK -> all outputs 0 next cycle; start ignored while reset low.
